// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB first, one full-adder step per clock, start/done handshake.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds the sub_i port).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] load_b;
    logic             load_carry;
    logic             ha0_s, ha0_c, ha1_s, ha1_c;
    logic             carry_nxt;

    // Subtraction is a + ~b + 1: invert B and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign load_b     = sub_i ? ~b_i : b_i;
    assign load_carry = sub_i;
`else
    assign load_b     = b_i;
    assign load_carry = 1'b0;
`endif

    // Full adder built from two half adders plus an OR.
    assign ha0_s     = a_sr_q[0] ^ b_sr_q[0];
    assign ha0_c     = a_sr_q[0] & b_sr_q[0];
    assign ha1_s     = ha0_s ^ carry_q;
    assign ha1_c     = ha0_s & carry_q;
    assign carry_nxt = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    a_sr_d  = a_i;
                    b_sr_d  = load_b;
                    carry_d = load_carry;
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                sum_d   = {ha1_s, sum_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    c_out_d = carry_nxt;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o  = (state_q == StShift);
    assign done_o  = (state_q == StDone);
    assign sum_o   = sum_q;
    assign c_out_o = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes {c_out,sum} expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;
    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] a_i, b_i;
    logic         sub_i;
    logic         busy_o, done_o, c_out_o;
    logic [W-1:0] sum_o;

    logic [W:0]   exp_q[$];
    logic [W:0]   last_exp;
    int           n_cmp = 0;
    int           n_bad = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .start_i(start_i),
        .a_i    (a_i),
        .b_i    (b_i),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i  (sub_i),
`endif
        .busy_o (busy_o),
        .done_o (done_o),
        .sum_o  (sum_o),
        .c_out_o(c_out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
        if (s) return {a >= b, W'(a - b)};
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("result", 32'({c_out_o, sum_o}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE/DONE, check latency, return inside the DONE cycle.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int bad;
        a_i = a;
        b_i = b;
        sub_i = s;
        start_i = 1'b1;
        last_exp = model(a, b, s);
        exp_q.push_back(last_exp);
        tick();
        start_i = 1'b0;
        bad = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (!busy_o || done_o) bad++;
            tick();
        end
        chk("busy_window", 32'(bad), 32'd0);
        chk("done_latency", 32'({done_o, busy_o}), 32'b10);
    endtask

    task automatic hold_check();
        tick();
        chk("hold_done", 32'({done_o, busy_o}), 32'd0);
        chk("hold_value", 32'({c_out_o, sum_o}), 32'(last_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst_i = 1'b1;
        start_i = 1'b1;
        a_i = 8'hFF;
        b_i = 8'hFF;
        sub_i = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 32'({busy_o, done_o, c_out_o, sum_o}), 32'd0);
        rst_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("idle_after_reset", 32'({busy_o, done_o}), 32'd0);

        // Directed adds
        op(8'h0F, 8'h01, 1'b0);
        hold_check();
        hold_check();
        op(8'hFF, 8'h01, 1'b0);
        hold_check();
        op(8'hFF, 8'hFF, 1'b0);
        hold_check();

        // start during SHIFT must be ignored
        a_i = 8'h0F;
        b_i = 8'h01;
        start_i = 1'b1;
        last_exp = model(8'h0F, 8'h01, 1'b0);
        exp_q.push_back(last_exp);
        tick();
        start_i = 1'b0;
        tick();
        tick();
        a_i = 8'h01;
        b_i = 8'h01;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 0;
        while (!done_o && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("ignored_start_done", 32'(done_o), 32'd1);
        for (int i = 0; i < int'(W) + 3; i++) tick();
        chk("ignored_start_idle", 32'({busy_o, done_o}), 32'd0);

        // Back-to-back: start issued inside the DONE cycle
        op(8'h01, 8'h02, 1'b0);
        op(8'h22, 8'h11, 1'b0);
        hold_check();

        // Abort with reset at the 4th SHIFT cycle
        a_i = 8'h0F;
        b_i = 8'h01;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_outputs", 32'({busy_o, done_o, c_out_o, sum_o}), 32'd0);
        for (int i = 0; i < int'(W) + 3; i++) tick();
        chk("abort_no_done", 32'({busy_o, done_o}), 32'd0);
        op(8'h03, 8'h04, 1'b0);
        hold_check();

`ifdef SERIAL_ADDER_SUB_EN
        op(8'h05, 8'h07, 1'b1);
        hold_check();
        op(8'h07, 8'h05, 1'b1);
        hold_check();
        op(8'h07, 8'h05, 1'b0);
        hold_check();
`endif

        // Randomised ops with random idle gaps (0 gap = back-to-back)
        for (int n = 0; n < 60; n++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            op(W'($urandom), W'($urandom), s);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
